// File: rtl/bram_stream_writer_if.sv
// Stream sink, BRAM port-A and loader handshake bundle for bram_stream_writer.
// Latency: n/a (wiring only). Backpressure: s_ready from the writer, load_ack from the loader.
// The writer connects through the slave modport. The stream source, BRAM and loader use master.
interface bram_stream_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    logic                  BRAM_ena;
    logic                  BRAM_wea;
    logic [ADDR_W-1:0]     BRAM_addra;
    logic [DATA_WIDTH-1:0] BRAM_dina;

    logic                  load_done;
    logic                  load_ack;
    logic [ADDR_W:0]       word_cnt;
    logic                  len_err;

    modport slave (
        input  s_data, s_valid, s_last, load_ack,
        output s_ready, BRAM_ena, BRAM_wea, BRAM_addra, BRAM_dina,
        output load_done, word_cnt, len_err
    );

    modport master (
        output s_data, s_valid, s_last, load_ack,
        input  s_ready, BRAM_ena, BRAM_wea, BRAM_addra, BRAM_dina,
        input  load_done, word_cnt, len_err
    );
endinterface

// File: rtl/bram_stream_writer.sv
// Writes one valid/ready frame into BRAM port A, then presents load_done until load_ack.
// Latency: write strobe 1 cycle after accept; load_done 2 cycles after the last beat.
// Backpressure: s_ready is low from the last beat until load_ack is seen. Optional length checking: BRAM_WRITER_LEN_CHECK_EN.
module bram_stream_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bram_stream_writer_if.slave     bus
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      ptr_q,   ptr_d;
    logic                  wr_q,    wr_d;
    logic [ADDR_W-1:0]     addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] din_q,   din_d;

    logic accept;
    logic at_last_idx;
    logic frame_end;
    logic release_frame;

    assign accept        = bus.s_valid && (state_q == ST_FILL);
    assign at_last_idx   = (ptr_q == LAST_IDX);
    assign frame_end     = accept && (bus.s_last || at_last_idx);
    assign release_frame = (state_q == ST_DONE) && bus.load_ack;

    // ptr_q counts accepted beats, which equals the number of strobes already visible.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    addr_d = ptr_q[ADDR_W-1:0];
                    din_d  = bus.s_data;
                    ptr_d  = ptr_q + CNT_W'(1);
                    if (frame_end) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (release_frame) begin
                    state_d = ST_FILL;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

`ifdef BRAM_WRITER_LEN_CHECK_EN
    logic err_q, err_d;

    // A frame is well-formed only when s_last arrives exactly on the final BRAM slot.
    always_comb begin
        err_d = err_q;
        if (frame_end && (bus.s_last ^ at_last_idx)) begin
            err_d = 1'b1;
        end else if (release_frame) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.len_err = err_q;
`else
    assign bus.len_err = 1'b0;
`endif

    assign bus.s_ready    = (state_q == ST_FILL);
    assign bus.load_done  = (state_q == ST_DONE);
    assign bus.word_cnt   = ptr_q;
    assign bus.BRAM_ena   = wr_q;
    assign bus.BRAM_wea   = wr_q;
    assign bus.BRAM_addra = addr_q;
    assign bus.BRAM_dina  = din_q;

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed bench for bram_stream_writer with DEPTH=4: a per-cycle vector table plus hand-written
// sequences covering the long DONE hold and the mid-frame reset.
module tb_bram_stream_writer;

`ifdef BRAM_WRITER_LEN_CHECK_EN
    localparam logic LEN_E = 1'b1;
`else
    localparam logic LEN_E = 1'b0;
`endif

    logic clk;
    logic rst_n;

    bram_stream_writer_if #(.DATA_WIDTH(16), .ADDR_W(2)) bus ();

    bram_stream_writer #(.DATA_WIDTH(16), .DEPTH(4), .ADDR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        l;
        logic [15:0] d;
        logic        ack;
        logic        rdy;
        logic        ena;
        logic [1:0]  addr;
        logic [15:0] din;
        logic        done;
        logic [2:0]  cnt;
        logic        err;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic v, input logic l, input logic [15:0] d, input logic ack,
                       input logic rdy, input logic ena, input logic [1:0] addr,
                       input logic [15:0] din, input logic done, input logic [2:0] cnt,
                       input logic err);
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.ack = ack;
        r.rdy = rdy; r.ena = ena; r.addr = addr; r.din = din;
        r.done = done; r.cnt = cnt; r.err = err;
        tv.push_back(r);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [15:0] d, input logic ack);
        bus.s_valid  = v;
        bus.s_last   = l;
        bus.s_data   = d;
        bus.load_ack = ack;
    endtask

    task automatic chk_reset_vals(input int tag);
        chk("rst_ready", tag, 32'(bus.s_ready),    32'd1);
        chk("rst_ena",   tag, 32'(bus.BRAM_ena),   32'd0);
        chk("rst_wea",   tag, 32'(bus.BRAM_wea),   32'd0);
        chk("rst_addr",  tag, 32'(bus.BRAM_addra), 32'd0);
        chk("rst_din",   tag, 32'(bus.BRAM_dina),  32'd0);
        chk("rst_done",  tag, 32'(bus.load_done),  32'd0);
        chk("rst_cnt",   tag, 32'(bus.word_cnt),   32'd0);
        chk("rst_err",   tag, 32'(bus.len_err),    32'd0);
    endtask

    initial begin
        int wait_cycles;

        // Rows are cycles: inputs driven that cycle, outputs observed in that same cycle.
        //   v  l  data     ack | rdy ena addr din      done cnt err
        add(1, 0, 16'hA1, 0,   1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0, 16'hA2, 0,   1, 1, 0, 16'h00A1, 0, 1, 0);
        add(1, 0, 16'hA3, 0,   1, 1, 1, 16'h00A2, 0, 2, 0);
        add(1, 1, 16'hA4, 0,   1, 1, 2, 16'h00A3, 0, 3, 0);
        add(1, 0, 16'hBB, 0,   0, 1, 3, 16'h00A4, 0, 4, 0);
        add(1, 0, 16'hBB, 0,   0, 0, 0, 16'h0000, 1, 4, 0);
        add(1, 0, 16'hBB, 1,   0, 0, 0, 16'h0000, 1, 4, 0);
        add(0, 0, 16'h00, 0,   1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0, 16'hB0, 0,   1, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 16'h00, 0,   1, 1, 0, 16'h00B0, 0, 1, 0);
        add(1, 0, 16'hB1, 0,   1, 0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h00, 0,   1, 1, 1, 16'h00B1, 0, 2, 0);
        add(1, 0, 16'hB2, 0,   1, 0, 0, 16'h0000, 0, 2, 0);
        add(0, 0, 16'h00, 0,   1, 1, 2, 16'h00B2, 0, 3, 0);
        add(1, 1, 16'hB3, 0,   1, 0, 0, 16'h0000, 0, 3, 0);
        add(0, 0, 16'h00, 0,   0, 1, 3, 16'h00B3, 0, 4, 0);
        add(0, 0, 16'h00, 0,   0, 0, 0, 16'h0000, 1, 4, 0);
        add(0, 0, 16'h00, 1,   0, 0, 0, 16'h0000, 1, 4, 0);
        add(1, 0, 16'hC0, 0,   1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 1, 16'hC1, 0,   1, 1, 0, 16'h00C0, 0, 1, 0);
        add(1, 0, 16'hCC, 0,   0, 1, 1, 16'h00C1, 0, 2, LEN_E);
        add(1, 0, 16'hCC, 1,   0, 0, 0, 16'h0000, 1, 2, LEN_E);
        add(1, 0, 16'hD0, 1,   1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 1, 16'hD1, 1,   1, 1, 0, 16'h00D0, 0, 1, 0);
        add(1, 0, 16'hDD, 1,   0, 1, 1, 16'h00D1, 0, 2, LEN_E);
        add(1, 0, 16'hDD, 1,   0, 0, 0, 16'h0000, 1, 2, LEN_E);
        add(0, 0, 16'h00, 0,   1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0, 16'hE0, 0,   1, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0, 16'hE1, 0,   1, 1, 0, 16'h00E0, 0, 1, 0);
        add(1, 0, 16'hE2, 0,   1, 1, 1, 16'h00E1, 0, 2, 0);
        add(1, 0, 16'hE3, 0,   1, 1, 2, 16'h00E2, 0, 3, 0);
        add(1, 1, 16'hEE, 0,   0, 1, 3, 16'h00E3, 0, 4, LEN_E);
        add(1, 1, 16'hEE, 0,   0, 0, 0, 16'h0000, 1, 4, LEN_E);
        add(0, 0, 16'h00, 1,   0, 0, 0, 16'h0000, 1, 4, LEN_E);
        add(0, 0, 16'h00, 0,   1, 0, 0, 16'h0000, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 16'h0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals(0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(tv[i].v, tv[i].l, tv[i].d, tv[i].ack);
            #1;
            chk("ready", i, 32'(bus.s_ready),   32'(tv[i].rdy));
            chk("ena",   i, 32'(bus.BRAM_ena),  32'(tv[i].ena));
            chk("wea",   i, 32'(bus.BRAM_wea),  32'(tv[i].ena));
            chk("done",  i, 32'(bus.load_done), 32'(tv[i].done));
            chk("cnt",   i, 32'(bus.word_cnt),  32'(tv[i].cnt));
            chk("err",   i, 32'(bus.len_err),   32'(tv[i].err));
            if (tv[i].ena) begin
                chk("addr", i, 32'(bus.BRAM_addra), 32'(tv[i].addr));
                chk("din",  i, 32'(bus.BRAM_dina),  32'(tv[i].din));
            end
        end

        // Long DONE hold: s_valid stays high but nothing may be accepted or written.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, k == 3, 16'h0F0 + 16'(k), 0);
        end
        @(negedge clk);
        drive(1, 0, 16'h0BAD, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("hold_ready", k, 32'(bus.s_ready),   32'd0);
            chk("hold_ena",   k, 32'(bus.BRAM_ena),  32'd0);
            chk("hold_done",  k, 32'(bus.load_done), 32'd1);
            chk("hold_cnt",   k, 32'(bus.word_cnt),  32'd4);
        end
        @(negedge clk);
        drive(1, 0, 16'h0BAD, 1);
        @(negedge clk);
        drive(1, 0, 16'h0055, 0);
        #1;
        chk("ack_ready", 0, 32'(bus.s_ready),   32'd1);
        chk("ack_done",  0, 32'(bus.load_done), 32'd0);
        chk("ack_cnt",   0, 32'(bus.word_cnt),  32'd0);
        @(negedge clk);
        drive(1, 0, 16'h0066, 0);
        #1;
        chk("nf_ena",  0, 32'(bus.BRAM_ena),   32'd1);
        chk("nf_addr", 0, 32'(bus.BRAM_addra), 32'd0);
        chk("nf_din",  0, 32'(bus.BRAM_dina),  32'h55);

        // Reset while the second beat's write strobe is pending.
        @(negedge clk);
        drive(0, 0, 16'h0, 0);
        #1;
        chk("pre_rst_ena",  0, 32'(bus.BRAM_ena),   32'd1);
        chk("pre_rst_addr", 0, 32'(bus.BRAM_addra), 32'd1);
        chk("pre_rst_cnt",  0, 32'(bus.word_cnt),   32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(1);
        @(negedge clk);
        #1;
        chk_reset_vals(2);
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, k == 3, 16'h0070 + 16'(k), 0);
            #1;
            chk("rf_done", k, 32'(bus.load_done), 32'd0);
            chk("rf_ena",  k, 32'(bus.BRAM_ena),  32'(k != 0));
            if (k != 0) begin
                chk("rf_addr", k, 32'(bus.BRAM_addra), 32'(k - 1));
                chk("rf_din",  k, 32'(bus.BRAM_dina),  32'h70 + 32'(k - 1));
            end
        end
        @(negedge clk);
        drive(0, 0, 16'h0, 0);
        #1;
        chk("rf_ena",  4, 32'(bus.BRAM_ena),   32'd1);
        chk("rf_addr", 4, 32'(bus.BRAM_addra), 32'd3);
        chk("rf_din",  4, 32'(bus.BRAM_dina),  32'h73);
        chk("rf_done", 4, 32'(bus.load_done),  32'd0);

        wait_cycles = 0;
        while (!bus.load_done && wait_cycles < 8) begin
            @(negedge clk);
            #1;
            wait_cycles++;
        end
        chk("rf_done_lat", 0, 32'(wait_cycles),   32'd1);
        chk("rf_cnt",      0, 32'(bus.word_cnt),  32'd4);
        chk("rf_err",      0, 32'(bus.len_err),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_stream_writer.md
BRAM_STREAM_WRITER -- requirements
Module: bram_stream_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one BRAM word and of the stream data.
REQ-002 Parameter DEPTH, default 256, maximum words per frame (BRAM depth).
REQ-003 Parameter ADDR_W, default 8, BRAM address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_data  input  DATA_WIDTH  stream word.
REQ-007 s_valid  input  1  s_data/s_last valid.
REQ-008 s_last  input  1  final word of frame.
REQ-009 s_ready  output  1  writer accepts a word this cycle.
REQ-010 BRAM_ena  output  1  BRAM port-A enable.
REQ-011 BRAM_wea  output  1  BRAM port-A write strobe.
REQ-012 BRAM_addra  output  ADDR_W  BRAM port-A address.
REQ-013 BRAM_dina  output  DATA_WIDTH  BRAM port-A write data.
REQ-014 load_done  output  1  frame fully committed to BRAM; valid to downstream loader.
REQ-015 load_ack  input  1  downstream loader ready; completes load_done handshake.
REQ-016 word_cnt  output  ADDR_W+1  words committed in current/last frame.
REQ-017 len_err  output  1  frame length error flag (see Configuration).

Function
REQ-018 FSM states FILL, FLUSH, DONE; SHALL leave reset in FILL.
REQ-019 s_ready SHALL be 1 exactly in FILL; a beat is accepted when s_valid && s_ready.
REQ-020 Accepted beat at cycle N SHALL produce BRAM_ena=BRAM_wea=1, BRAM_addra=write pointer, BRAM_dina=s_data at cycle N+1 (registered); otherwise ena/wea SHALL be 0.
REQ-021 Write pointer SHALL start at 0 per frame and increment by 1 per accepted beat; no wrap.
REQ-022 FILL->FLUSH on the accepted beat carrying s_last=1 or the DEPTH-th accepted beat, whichever first.
REQ-023 FLUSH SHALL last exactly one cycle (final write strobe issues), then ->DONE.
REQ-024 load_done SHALL be 1 exactly in DONE: last beat accepted at N -> load_done=1 at N+2.
REQ-025 DONE->FILL on the cycle load_ack=1; load_done low and s_ready high the next cycle; write pointer cleared to 0.
REQ-026 load_ack outside DONE SHALL be ignored; s_valid outside FILL SHALL not be accepted and SHALL not write.
REQ-027 word_cnt SHALL equal number of write strobes issued in current frame; holds through DONE; clears to 0 on DONE->FILL.
REQ-028 load_ack asserted continuously: each frame still spends at least one cycle in DONE.
REQ-029 s_valid low mid-frame: no write, pointer holds, FSM stays in FILL.

Reset
REQ-030 On rst_n=0 all outputs SHALL be 0 except s_ready: state=FILL, pointer=0, word_cnt=0, len_err=0, load_done=0, BRAM_ena/wea/addra/dina=0.
REQ-031 Reset mid-frame or in DONE SHALL discard the partial frame; a pending write strobe SHALL be suppressed asynchronously; s_ready=1 once reset released.

Configuration
REQ-032 Macro BRAM_WRITER_LEN_CHECK_EN.
REQ-033 Defined: len_err SHALL set (sticky, with load_done) when a frame ends by s_last on beat index != DEPTH-1, or by DEPTH beats without s_last; cleared on DONE->FILL; frame termination per REQ-022 unchanged.
REQ-034 Undefined: len_err SHALL be constant 0; no checking logic synthesised.

Verification
REQ-035 DEPTH=4, s_valid steady, words 0xA1..0xA4 with s_last on 4th -> wea at addr 0..3 on cycles N+1..N+4, load_done at N+5, word_cnt=4, len_err=0.
REQ-036 s_valid gapped (1,0,1,0...) over 4 words -> writes only on accepted beats, addresses contiguous 0..3, no write in gap cycles.
REQ-037 s_last on 2nd word, DEPTH=4 -> word_cnt=2, load_done; len_err=1 with macro, 0 without.
REQ-038 load_done held, load_ack low 10 cycles -> s_ready=0, no writes despite s_valid=1; load_ack=1 -> next cycle s_ready=1, word_cnt=0, next frame writes from addr 0.
REQ-039 rst_n pulsed low after 2 of 4 beats -> all outputs reset values, next frame starts at addr 0, load_done only after full new frame.
